// File: rtl/wave_gen.sv
// wave_gen: phase-accumulator test-signal source (square / sawtooth / triangle).
// A shadowed configuration swaps into the active registers at a period boundary.
module wave_gen #(
    parameter int PHASE_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_inc,
    input  logic [1:0]         cfg_wave,
    input  logic [7:0]         cfg_duty,
    output logic [9:0]         data_out,
    output logic               data_valid,
    output logic               sync
);

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_OFF    = 2'd3
    } wave_e;

    localparam logic [7:0] DUTY_HALF = 8'd128;

    // Active configuration and phase
    logic [PHASE_W-1:0] acc;
    logic [PHASE_W-1:0] inc;
    wave_e              wave;
    logic [7:0]         duty;

    // Shadow configuration awaiting a period boundary
    logic [PHASE_W-1:0] sh_inc;
    wave_e              sh_wave;
    logic [7:0]         sh_duty;
    logic               pending;

    // Set on the carry edge so the sample of the wrapped phase carries sync
    logic               wrapped;

    logic [PHASE_W:0]   sum;
    logic               carry;
    logic               xfer;
    logic               apply_idle;
    logic               apply_carry;
    logic [7:0]         phase;
    logic [8:0]         tri_wide;
    logic [8:0]         sample;

    assign sum         = {1'b0, acc} + {1'b0, inc};
    assign carry       = sum[PHASE_W];
    assign cfg_ready   = !pending;
    assign xfer        = cfg_valid && !pending;
    assign apply_idle  = pending && (!en || inc == '0);
    assign apply_carry = pending && en && carry;
    assign phase       = acc[PHASE_W-1 -: 8];

    // Triangle folds in 9 bits; the falling half is 2*(255-p)+1, never above 255.
    always_comb begin
        // NOTE: defaults first, so every path assigns and no latch is inferred.
        sample   = 9'd0;
        tri_wide = phase[7] ? {8'd255 - phase, 1'b1} : {phase, 1'b0};
        case (wave)
            WAVE_SQUARE: sample = (phase < duty) ? 9'd255 : 9'd0;
            WAVE_SAW:    sample = {1'b0, phase};
            WAVE_TRI:    sample = tri_wide;
            default:     sample = 9'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            inc     <= '0;
            wave    <= WAVE_SQUARE;
            duty    <= DUTY_HALF;
            sh_inc  <= '0;
            sh_wave <= WAVE_SQUARE;
            sh_duty <= DUTY_HALF;
            pending <= 1'b0;
            wrapped <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every read at the pre-edge value.
            if (apply_idle) begin
                acc     <= '0;
                wrapped <= 1'b0;
                inc     <= sh_inc;
                wave    <= sh_wave;
                duty    <= sh_duty;
                pending <= 1'b0;
            end else if (en) begin
                acc     <= sum[PHASE_W-1:0];
                wrapped <= carry;
                if (apply_carry) begin
                    inc     <= sh_inc;
                    wave    <= sh_wave;
                    duty    <= sh_duty;
                    pending <= 1'b0;
                end
            end

            // Accepted only while nothing is pending, so it never collides with an apply
            if (xfer) begin
                sh_inc  <= cfg_inc;
                sh_wave <= wave_e'(cfg_wave);
                sh_duty <= cfg_duty;
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            sync       <= 1'b0;
        end else if (en) begin
            data_out   <= {1'b0, sample};
            data_valid <= 1'b1;
            sync       <= wrapped;
        end else begin
            data_valid <= 1'b0;
            sync       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wave_gen.sv
// Self-checking bench for wave_gen: per-cycle reference model plus directed
// scenarios with hand-computed sample values.
module tb_wave_gen;

    localparam longint unsigned FULL = 64'h1_0000_0000;
    localparam longint unsigned STEP = FULL / 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_inc = '0;
    logic [1:0]  cfg_wave = '0;
    logic [7:0]  cfg_duty = '0;
    logic [9:0]  data_out;
    logic        data_valid;
    logic        sync;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    int s [0:299];
    bit y [0:299];

    wave_gen #(.PHASE_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_inc    (cfg_inc),
        .cfg_wave   (cfg_wave),
        .cfg_duty   (cfg_duty),
        .data_out   (data_out),
        .data_valid (data_valid),
        .sync       (sync)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    longint unsigned m_acc, m_inc, m_sh_inc;
    int m_wave, m_duty, m_sh_wave, m_sh_duty;
    bit m_pend, m_after_carry;
    int m_out;
    bit m_valid, m_sync;

    function automatic int shape(input int p, input int w, input int d);
        case (w)
            0:       return (p < d) ? 255 : 0;
            1:       return p;
            2:       return (p < 128) ? 2 * p : 2 * (255 - p) + 1;
            default: return 0;
        endcase
    endfunction

    task automatic m_take_shadow();
        m_inc  = m_sh_inc;
        m_wave = m_sh_wave;
        m_duty = m_sh_duty;
        m_pend = 1'b0;
    endtask

    always @(posedge clk or negedge rst) begin : model
        longint unsigned next_phase;
        bit carried;
        bit took;
        if (!rst) begin
            m_acc = 0; m_inc = 0; m_wave = 0; m_duty = 128;
            m_sh_inc = 0; m_sh_wave = 0; m_sh_duty = 128;
            m_pend = 0; m_after_carry = 0;
            m_out = 0; m_valid = 0; m_sync = 0;
        end else begin
            next_phase = m_acc + m_inc;
            carried    = next_phase >= FULL;
            took       = cfg_valid && !m_pend;
            if (en) begin
                m_out   = shape(int'(m_acc / STEP), m_wave, m_duty);
                m_valid = 1;
                m_sync  = m_after_carry;
            end else begin
                m_valid = 0;
                m_sync  = 0;
            end
            if (m_pend && (!en || m_inc == 0)) begin
                m_take_shadow();
                m_acc = 0;
                m_after_carry = 0;
            end else if (en) begin
                m_acc = next_phase % FULL;
                m_after_carry = carried;
                if (m_pend && carried) m_take_shadow();
            end
            if (took) begin
                m_sh_inc  = cfg_inc;
                m_sh_wave = cfg_wave;
                m_sh_duty = cfg_duty;
                m_pend    = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_data_out", data_out, m_out);
            check("cmp_data_valid", data_valid, m_valid);
            check("cmp_sync", sync, m_sync);
            check("cmp_cfg_ready", cfg_ready, !m_pend);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] inc, input logic [1:0] w, input logic [7:0] d);
        cfg_inc   = inc;
        cfg_wave  = w;
        cfg_duty  = d;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time %0t, expected finish well before", $time);
        $fatal(1);
    end

    initial begin : stim
        int cnt;
        int nsync;
        int first_sync;
        int rise_at;
        int fall_at;
        bit found;

        #2 rst = 1'b0;
        cmp_en = 1'b1;
        #20;
        check("reset_data_out", data_out, 0);
        check("reset_data_valid", data_valid, 0);
        check("reset_sync", sync, 0);
        check("reset_cfg_ready", cfg_ready, 1);
        tick();
        rst = 1'b1;

        // Idle run, inc = 0: square at 50 % with phase 0 reads high, never wraps
        en = 1'b1;
        nsync = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sync) nsync++;
        end
        check("idle_data_out", data_out, 255);
        check("idle_data_valid", data_valid, 1);
        check("idle_sync_count", nsync, 0);
        check("idle_cfg_ready", cfg_ready, 1);

        // Square, duty 128, 64-cycle period, applied while stopped
        en = 1'b0;
        offer(32'h0400_0000, 2'd0, 8'd128);
        check("sq_ready_low", cfg_ready, 0);
        tick();
        check("sq_ready_back", cfg_ready, 1);
        en = 1'b1;
        for (int i = 0; i < 130; i++) begin
            tick();
            s[i] = data_out;
            y[i] = sync;
        end
        check("sq_s0", s[0], 255);
        check("sq_s31", s[31], 255);
        check("sq_s32", s[32], 0);
        check("sq_s63", s[63], 0);
        check("sq_s64", s[64], 255);
        nsync = 0;
        first_sync = -1;
        for (int i = 0; i < 130; i++) begin
            if (y[i]) begin
                nsync++;
                if (first_sync < 0) first_sync = i;
            end
        end
        check("sq_sync_count", nsync, 2);
        check("sq_first_sync", first_sync, 64);
        check("sq_sync_period", y[128], 1);

        // Triangle, 256-cycle period
        en = 1'b0;
        offer(32'h0100_0000, 2'd2, 8'd128);
        tick();
        en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tick();
            s[i] = data_out;
        end
        check("tri_s0", s[0], 0);
        check("tri_s1", s[1], 2);
        check("tri_s127", s[127], 254);
        check("tri_s128", s[128], 255);
        check("tri_s129", s[129], 253);
        check("tri_s255", s[255], 1);
        rise_at = -1;
        fall_at = -1;
        for (int i = 1; i < 256; i++) begin
            if (rise_at < 0 && s[i-1] < 128 && s[i] >= 128) rise_at = i;
            if (fall_at < 0 && s[i-1] >= 128 && s[i] < 128) fall_at = i;
        end
        check("tri_half_period", fall_at - rise_at, 128);

        // Mid-period switch to sawtooth, inc 0x0200_0000
        for (int i = 0; i < 100; i++) tick();
        offer(32'h0200_0000, 2'd1, 8'd128);
        check("mid_ready_low", cfg_ready, 0);
        cnt = 0;
        while (!cfg_ready && cnt < 300) begin
            tick();
            cnt++;
        end
        check("mid_ready_back", cfg_ready, 1);
        check("mid_wait_edges", cnt, 155);
        check("mid_last_tri", data_out, 1);
        tick();
        check("mid_saw_first", data_out, 0);
        check("mid_saw_sync", sync, 1);
        tick();
        check("mid_saw_second", data_out, 2);
        check("mid_saw_nosync", sync, 0);

        // Offer landing exactly on a carry edge waits a full period
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (data_out == 10'd252) found = 1'b1;
        end
        check("edge_found_252", found, 1);
        offer(32'h0200_0000, 2'd0, 8'd64);
        check("edge_ready_low", cfg_ready, 0);
        check("edge_old_sample", data_out, 254);
        tick();
        check("edge_still_saw", data_out, 0);
        check("edge_sync", sync, 1);
        cnt = 1;
        while (!cfg_ready && cnt < 300) begin
            tick();
            cnt++;
        end
        check("edge_wait_edges", cnt, 128);
        tick();
        check("edge_new_square", data_out, 255);
        check("edge_new_sync", sync, 1);

        // Reset with a config pending: everything returns to reset values
        for (int i = 0; i < 10; i++) tick();
        offer(32'h0100_0000, 2'd2, 8'd128);
        check("rst_pending", cfg_ready, 0);
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        check("rst_data_out", data_out, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_sync", sync, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        tick();
        rst = 1'b1;
        nsync = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sync) nsync++;
        end
        check("post_rst_data_out", data_out, 255);
        check("post_rst_sync_count", nsync, 0);
        check("post_rst_cfg_ready", cfg_ready, 1);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
